// File: rtl/myproject_mac_pipe_16s_5s_acc.sv
// rtl/myproject_mac_pipe_16s_5s_acc.sv - pipelined signed multiply-accumulate with round/shift/saturate output
module myproject_mac_pipe_16s_5s_acc #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 5,
    parameter int ACC_WIDTH  = 32,
    parameter int SHIFT      = 6,
    parameter int dout_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW  = din0_WIDTH + din1_WIDTH;
    localparam int AW1 = ACC_WIDTH + 1;

    // Saturation bounds and rounding offset, all in the widened output-formation domain
    localparam logic signed [AW1-1:0] OUT_MAX = AW1'((64'sd1 <<< (dout_WIDTH - 1)) - 64'sd1);
    localparam logic signed [AW1-1:0] OUT_MIN = ~OUT_MAX;
    localparam logic signed [AW1-1:0] RND     =
        AW1'((SHIFT > 0) ? (64'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 64'sd0);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Operand capture stage feeding the multiplier
    logic signed [din0_WIDTH-1:0] a_q;
    logic signed [din1_WIDTH-1:0] b_q;
    logic                         in_v_q;
    logic                         in_l_q;
    logic signed [PW-1:0]         prod;

    // Product pipeline
    logic signed [PW-1:0]  p_pipe [NUM_STAGE];
    logic [NUM_STAGE-1:0]  v_pipe;
    logic [NUM_STAGE-1:0]  l_pipe;
    logic signed [PW-1:0]  p_exit;
    logic                  v_exit;
    logic                  l_exit;

    // Accumulator state
    state_t                      state_q;
    state_t                      state_d;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic                        load_out;

    // Output formation
    logic signed [AW1-1:0]        rnd_sum;
    logic signed [AW1-1:0]        r;
    logic [dout_WIDTH-1:0]        sat_dout;
    logic                         sat_ovf;

    assign prod   = PW'(a_q) * PW'(b_q);
    assign p_exit = p_pipe[NUM_STAGE-1];
    assign v_exit = v_pipe[NUM_STAGE-1];
    assign l_exit = l_pipe[NUM_STAGE-1];

    // Capture operands; last is only meaningful alongside a valid beat
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            a_q    <= '0;
            b_q    <= '0;
            in_v_q <= 1'b0;
            in_l_q <= 1'b0;
        end else if (ce) begin
            in_v_q <= in_valid;
            in_l_q <= in_valid & in_last;
            if (in_valid) begin
                a_q <= din0;
                b_q <= din1;
            end
        end
    end

    // Shift product, valid and last through NUM_STAGE registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                p_pipe[i] <= '0;
            end
            v_pipe <= '0;
            l_pipe <= '0;
        end else if (ce) begin
            p_pipe[0] <= prod;
            v_pipe[0] <= in_v_q;
            l_pipe[0] <= in_l_q;
            for (int i = 1; i < NUM_STAGE; i++) begin
                p_pipe[i] <= p_pipe[i-1];
                v_pipe[i] <= v_pipe[i-1];
                l_pipe[i] <= l_pipe[i-1];
            end
        end
    end

    // Next state / accumulator: first beat of a sequence starts from zero
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        load_out = 1'b0;
        acc_base = (state_q == IDLE) ? '0 : acc_q;
        acc_sum  = acc_base + ACC_WIDTH'(p_exit);
        if (v_exit) begin
            if (l_exit) begin
                state_d  = IDLE;
                acc_d    = '0;
                load_out = 1'b1;
            end else begin
                state_d = ACCUM;
                acc_d   = acc_sum;
            end
        end
    end

    // State and accumulator registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
        end else if (ce) begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // Round half toward +inf, arithmetic shift, then clamp to the output range
    always_comb begin
        rnd_sum  = AW1'(acc_sum) + RND;
        r        = rnd_sum >>> SHIFT;
        sat_dout = r[dout_WIDTH-1:0];
        sat_ovf  = 1'b0;
        if (r > OUT_MAX) begin
            sat_dout = OUT_MAX[dout_WIDTH-1:0];
            sat_ovf  = 1'b1;
        end else if (r < OUT_MIN) begin
            sat_dout = OUT_MIN[dout_WIDTH-1:0];
            sat_ovf  = 1'b1;
        end
    end

    // Output register: result held between sequences, valid pulses per last beat
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= load_out;
            if (load_out) begin
                dout <= sat_dout;
                ovf  <= sat_ovf;
            end
        end
    end

endmodule
